// File: rtl/vt_sensor_scan_ctrl.sv
// Scan sequencer for the VT-sensor RO bank: per masked RO it clears the ripple counter, opens a
// timed enable window, waits for the count to settle and hands it out over valid/ready.
module vt_sensor_scan_ctrl #(
  parameter int unsigned NUM_RO        = 9,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WIN_W         = 16,
  parameter int unsigned RST_CYCLES    = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [NUM_RO-1:0] i_ro_mask,
  input  logic [WIN_W-1:0]  i_window_cycles,
  input  logic [CNT_W-1:0]  i_cnt_in,
  output logic              o_sensor_en,
  output logic              o_cnt_rst,
  output logic [NUM_RO-1:0] o_ro_onehot,
  output logic [3:0]        o_ro_sel,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [3:0]        o_res_idx,
  output logic [CNT_W-1:0]  o_res_cnt,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {StIdle, StClr, StWin, StSettle, StCap, StNext} state_e;

  localparam logic [WIN_W-1:0]  RST_LOAD    = WIN_W'(RST_CYCLES - 1);
  localparam logic [WIN_W-1:0]  SETTLE_LOAD = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [NUM_RO-1:0] ONEHOT_LSB  = {{(NUM_RO-1){1'b0}}, 1'b1};

  function automatic logic [3:0] lowest_idx(input logic [NUM_RO-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

  state_e             r_state, w_state_d;
  logic [WIN_W-1:0]   r_cnt, w_cnt_d;
  logic [WIN_W-1:0]   r_win, w_win_d;
  logic [NUM_RO-1:0]  r_mask, w_mask_d;
  logic               r_sensor_en, w_sensor_en_d;
  logic               r_cnt_rst, w_cnt_rst_d;
  logic [NUM_RO-1:0]  r_ro_onehot, w_ro_onehot_d;
  logic [3:0]         r_ro_sel, w_ro_sel_d;
  logic               r_res_valid, w_res_valid_d;
  logic [3:0]         r_res_idx, w_res_idx_d;
  logic [CNT_W-1:0]   r_res_cnt, w_res_cnt_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic [3:0]         w_start_idx, w_rem_idx;

  assign w_start_idx = lowest_idx(i_ro_mask);
  // r_mask has already-served ROs cleared, so its lowest bit is the next RO above the current one
  assign w_rem_idx   = lowest_idx(r_mask);

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_win_d       = r_win;
    w_mask_d      = r_mask;
    w_sensor_en_d = r_sensor_en;
    w_cnt_rst_d   = r_cnt_rst;
    w_ro_onehot_d = r_ro_onehot;
    w_ro_sel_d    = r_ro_sel;
    w_res_valid_d = r_res_valid;
    w_res_idx_d   = r_res_idx;
    w_res_cnt_d   = r_res_cnt;
    w_busy_d      = r_busy;
    w_done_d      = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_mask_d = i_ro_mask;
          w_win_d  = (i_window_cycles == '0) ? WIN_W'(1) : i_window_cycles;
          if (i_ro_mask != '0) begin
            w_state_d     = StClr;
            w_ro_sel_d    = w_start_idx;
            w_ro_onehot_d = ONEHOT_LSB << w_start_idx;
            w_cnt_rst_d   = 1'b1;
            w_busy_d      = 1'b1;
            w_cnt_d       = RST_LOAD;
          end else begin
            w_done_d = 1'b1;
          end
        end
      end
      StClr: begin
        if (r_cnt == '0) begin
          w_state_d     = StWin;
          w_cnt_rst_d   = 1'b0;
          w_sensor_en_d = 1'b1;
          w_cnt_d       = r_win - WIN_W'(1);
        end else begin
          w_cnt_d = r_cnt - WIN_W'(1);
        end
      end
      StWin: begin
        if (r_cnt == '0) begin
          w_state_d     = StSettle;
          w_sensor_en_d = 1'b0;
          w_cnt_d       = SETTLE_LOAD;
        end else begin
          w_cnt_d = r_cnt - WIN_W'(1);
        end
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_state_d     = StCap;
          w_res_valid_d = 1'b1;
          w_res_cnt_d   = i_cnt_in;
          w_res_idx_d   = r_ro_sel;
        end else begin
          w_cnt_d = r_cnt - WIN_W'(1);
        end
      end
      StCap: begin
        if (r_res_valid && i_res_ready) begin
          w_state_d     = StNext;
          w_res_valid_d = 1'b0;
          w_mask_d      = r_mask & ~r_ro_onehot;
        end
      end
      StNext: begin
        if (r_mask != '0) begin
          w_state_d     = StClr;
          w_ro_sel_d    = w_rem_idx;
          w_ro_onehot_d = ONEHOT_LSB << w_rem_idx;
          w_cnt_rst_d   = 1'b1;
          w_cnt_d       = RST_LOAD;
        end else begin
          w_state_d     = StIdle;
          w_done_d      = 1'b1;
          w_ro_onehot_d = '0;
          w_ro_sel_d    = '0;
          w_busy_d      = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (i_abort && (r_state != StIdle)) begin
      w_state_d     = StIdle;
      w_sensor_en_d = 1'b0;
      w_cnt_rst_d   = 1'b0;
      w_ro_onehot_d = '0;
      w_ro_sel_d    = '0;
      w_res_valid_d = 1'b0;
      w_busy_d      = 1'b0;
      w_done_d      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_win       <= '0;
      r_mask      <= '0;
      r_sensor_en <= 1'b0;
      r_cnt_rst   <= 1'b0;
      r_ro_onehot <= '0;
      r_ro_sel    <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      r_res_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_win       <= w_win_d;
      r_mask      <= w_mask_d;
      r_sensor_en <= w_sensor_en_d;
      r_cnt_rst   <= w_cnt_rst_d;
      r_ro_onehot <= w_ro_onehot_d;
      r_ro_sel    <= w_ro_sel_d;
      r_res_valid <= w_res_valid_d;
      r_res_idx   <= w_res_idx_d;
      r_res_cnt   <= w_res_cnt_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

  assign o_sensor_en = r_sensor_en;
  assign o_cnt_rst   = r_cnt_rst;
  assign o_ro_onehot = r_ro_onehot;
  assign o_ro_sel    = r_ro_sel;
  assign o_res_valid = r_res_valid;
  assign o_res_idx   = r_res_idx;
  assign o_res_cnt   = r_res_cnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_vt_sensor_scan_ctrl.sv
// Directed bench for vt_sensor_scan_ctrl: table of whole-scan records plus hand sequences for
// backpressure, abort, start-while-busy and mid-scan reset.
module tb_vt_sensor_scan_ctrl;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0, i_start = 1'b0, i_abort = 1'b0, i_res_ready = 1'b0;
  logic [8:0]  i_ro_mask = '0;
  logic [15:0] i_window_cycles = '0, i_cnt_in = '0;
  logic        o_sensor_en, o_cnt_rst, o_res_valid, o_busy, o_done;
  logic [8:0]  o_ro_onehot;
  logic [3:0]  o_ro_sel, o_res_idx;
  logic [15:0] o_res_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vt_sensor_scan_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_ro_mask(i_ro_mask), .i_window_cycles(i_window_cycles), .i_cnt_in(i_cnt_in),
    .o_sensor_en(o_sensor_en), .o_cnt_rst(o_cnt_rst), .o_ro_onehot(o_ro_onehot),
    .o_ro_sel(o_ro_sel), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_idx(o_res_idx), .o_res_cnt(o_res_cnt), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    logic [8:0]  mask;
    logic [15:0] win;
    logic [15:0] cnt_a;     // count presented for the first RO
    logic [15:0] cnt_b;     // count presented for later ROs
    int          exp_res;
    int          exp_first;
    int          exp_last;
    int          exp_en;
    int          exp_rst;
    int          exp_done;  // cycle of DONE, counted from the START edge
  } scan_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_scan(input string tag, input scan_t v);
    int cyc = 1, done_cyc = 0, n_done = 0, n_en = 0, n_rst = 0, n_busy = 0, n_res = 0;
    int first_idx = 15, last_idx = 15, first_sel = 15, run = 0, bad_run = 0, bad_sel = 0;
    int weff;
    logic prev_en = 1'b0;
    logic [3:0] prev_sel = '0;
    logic [8:0] one = 9'd1;
    weff = (v.win == 0) ? 1 : int'(v.win);
    i_ro_mask = v.mask; i_window_cycles = v.win; i_res_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (cyc <= 400) begin
      if (o_sensor_en) begin
        n_en++; run++;
        i_cnt_in = 16'hDEAD;
        if (first_sel == 15) first_sel = o_ro_sel;
        if (o_ro_onehot != (one << o_ro_sel)) bad_sel++;
        if (prev_en && o_ro_sel != prev_sel) bad_sel++;
      end else if (prev_en) begin
        if (run != weff) bad_run++;
        run = 0;
        i_cnt_in = (n_res == 0) ? v.cnt_a : v.cnt_b;
      end
      if (o_cnt_rst) n_rst++;
      if (o_busy) n_busy++;
      if (o_res_valid) begin
        check({tag, "_res_cnt"}, o_res_cnt, (n_res == 0) ? v.cnt_a : v.cnt_b);
        if (n_res == 0) first_idx = o_res_idx;
        last_idx = o_res_idx;
        n_res++;
      end
      if (o_done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      prev_en = o_sensor_en; prev_sel = o_ro_sel;
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_n_results"}, n_res, v.exp_res);
    check({tag, "_first_idx"}, first_idx, v.exp_first);
    check({tag, "_last_idx"}, last_idx, v.exp_last);
    check({tag, "_first_sel"}, first_sel, (v.exp_res == 0) ? 15 : v.exp_first);
    check({tag, "_en_cycles"}, n_en, v.exp_en);
    check({tag, "_rst_cycles"}, n_rst, v.exp_rst);
    check({tag, "_busy_cycles"}, n_busy, (v.exp_done > 0) ? v.exp_done - 1 : 0);
    check({tag, "_window_len"}, bad_run, 0);
    check({tag, "_sel_stable"}, bad_sel, 0);
  endtask

  scan_t tbl[6];
  scan_t again;

  initial begin
    int k, bad, rises, act;
    logic prev;

    tbl[0] = '{9'h005, 16'd10, 16'd123,  16'd456,  2, 0, 2, 20, 4,  37};
    tbl[1] = '{9'h000, 16'd10, 16'd0,    16'd0,    0, 15, 15, 0, 0, 1};
    tbl[2] = '{9'h100, 16'd0,  16'd777,  16'd0,    1, 8, 8, 1,  2,  10};
    tbl[3] = '{9'h0A0, 16'd3,  16'h1111, 16'h2222, 2, 5, 7, 6,  4,  23};
    tbl[4] = '{9'h1FF, 16'd1,  16'hA5A5, 16'h5A5A, 9, 0, 8, 9,  18, 82};
    tbl[5] = '{9'h003, 16'd2,  16'd9,    16'd10,   2, 0, 1, 4,  4,  21};
    again  = '{9'h001, 16'd1,  16'd42,   16'd0,    1, 0, 0, 1,  2,  10};

    i_rst = 1'b1;
    repeat (3) tick();
    check("reset_outputs", {o_sensor_en, o_cnt_rst, o_ro_onehot, o_ro_sel, o_res_valid,
                            o_res_idx, o_res_cnt, o_busy, o_done}, 64'd0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_scan($sformatf("vec%0d", i), tbl[i]);
      repeat (2) tick();
    end

    // Backpressure: result must hold in CAP until RES_READY, next RO starts two cycles later
    i_ro_mask = 9'h006; i_window_cycles = 16'd2; i_res_ready = 1'b0; i_cnt_in = 16'h0BEE;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    k = 0;
    while (!o_res_valid && k < 100) begin tick(); k++; end
    check("bp_valid_seen", o_res_valid, 1);
    check("bp_first_cnt", o_res_cnt, 16'h0BEE);
    check("bp_first_idx", o_res_idx, 1);
    i_cnt_in = 16'h1234;
    bad = 0;
    repeat (20) begin
      tick();
      if (!o_res_valid || o_res_cnt != 16'h0BEE || o_res_idx != 4'd1 || o_cnt_rst || o_sensor_en)
        bad++;
    end
    check("bp_hold_stable", bad, 0);
    i_res_ready = 1'b1;
    tick();
    check("bp_valid_drop", o_res_valid, 0);
    check("bp_no_clr_yet", o_cnt_rst, 0);
    tick();
    check("bp_next_clr", o_cnt_rst, 1);
    check("bp_next_sel", o_ro_sel, 2);
    k = 0;
    while (!o_done && k < 100) begin tick(); k++; end
    check("bp_done_seen", o_done, 1);
    repeat (2) tick();

    // Abort inside the second RO's window
    i_ro_mask = 9'h1FF; i_window_cycles = 16'd5; i_res_ready = 1'b1; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    rises = 0; prev = 1'b0; k = 0;
    while (rises < 2 && k < 200) begin
      tick();
      if (o_sensor_en && !prev) rises++;
      prev = o_sensor_en;
      k++;
    end
    check("abort_reached_win2", rises, 2);
    check("abort_win2_sel", o_ro_sel, 1);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_sensor_en", o_sensor_en, 0);
    check("abort_busy", o_busy, 0);
    check("abort_outputs", {o_sensor_en, o_cnt_rst, o_ro_onehot, o_ro_sel, o_res_valid,
                            o_busy, o_done}, 64'd0);
    act = 0;
    repeat (30) begin tick(); if (o_busy || o_done || o_sensor_en || o_res_valid) act++; end
    check("abort_quiet", act, 0);
    run_scan("after_abort", again);
    repeat (2) tick();

    // START while busy is ignored
    i_ro_mask = 9'h004; i_window_cycles = 16'd3; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_ro_mask = 9'h1FF; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    bad = 0; act = 0; k = 0;
    while (!o_done && k < 100) begin
      if (o_res_valid) begin bad++; act = o_res_idx; end
      tick(); k++;
    end
    check("busy_start_done", o_done, 1);
    check("busy_start_results", bad, 1);
    check("busy_start_idx", act, 2);
    act = 0;
    repeat (15) begin tick(); if (o_busy || o_sensor_en) act++; end
    check("busy_start_ignored", act, 0);

    // Reset in the middle of SETTLE
    i_ro_mask = 9'h1FF; i_window_cycles = 16'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    prev = 1'b0; k = 0;
    while (k < 100) begin
      tick(); k++;
      if (prev && !o_sensor_en) break;
      prev = o_sensor_en;
    end
    check("rst_reached_settle", {o_busy, o_sensor_en, o_cnt_rst}, 3'b100);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_mid_outputs", {o_sensor_en, o_cnt_rst, o_ro_onehot, o_ro_sel, o_res_valid,
                              o_res_idx, o_res_cnt, o_busy, o_done}, 64'd0);
    act = 0;
    repeat (20) begin
      tick();
      if (o_busy || o_done || o_sensor_en || o_cnt_rst || o_res_valid) act++;
    end
    check("rst_idle", act, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
